// File: rtl/vga_sync_if.sv
// vga_sync_if: VGA timing outputs shared between the sync generator (master)
// and its consumers (slave).
interface vga_sync_if;
  logic hsync, vsync, video_on, p_tick, f_tick;
  logic [9:0] pix_x, pix_y;
  modport master (output hsync, vsync, video_on, p_tick, f_tick, pix_x, pix_y);
  modport slave (input hsync, vsync, video_on, p_tick, f_tick, pix_x, pix_y);
endinterface

// File: rtl/vga_sync.sv
// vga_sync: 640x480@60 Hz VGA timing generator; the pixel rate is clk/DIV.
module vga_sync #(
  parameter int DIV = 4,
  parameter bit SYNC_ACT = 1'b0
) (
  input logic clk,
  input logic reset,
  vga_sync_if.master vga
);
  localparam logic [9:0] H_END = 10'd799;
  localparam logic [9:0] V_END = 10'd524;
  localparam logic [3:0] P_END = 4'(DIV - 1);
  logic [3:0] cnt;
  logic [9:0] x, y, x_nx, y_nx;
  logic tick, hs, vs, ft, x_end, y_end;
  assign tick = cnt == P_END;
  // >= rather than == so a corrupted count still wraps on its next advance
  assign x_end = x >= H_END;
  assign y_end = y >= V_END;
  always_comb begin
    x_nx = tick ? (x_end ? '0 : x + 10'd1) : x;
    y_nx = tick && x_end ? (y_end ? '0 : y + 10'd1) : y;
  end
  // sync flops load from the next-state counts so they line up with pix_x/pix_y
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      x <= '0;
      y <= '0;
      hs <= ~SYNC_ACT;
      vs <= ~SYNC_ACT;
      ft <= 1'b0;
    end else begin
      cnt <= cnt >= P_END ? '0 : cnt + 4'd1;
      x <= x_nx;
      y <= y_nx;
      hs <= (x_nx >= 10'd656 && x_nx <= 10'd751) ? SYNC_ACT : ~SYNC_ACT;
      vs <= (y_nx >= 10'd490 && y_nx <= 10'd491) ? SYNC_ACT : ~SYNC_ACT;
      ft <= tick && x_end && y_end;
    end
  assign vga.hsync = hs;
  assign vga.vsync = vs;
  assign vga.p_tick = tick;
  assign vga.f_tick = ft;
  assign vga.pix_x = x;
  assign vga.pix_y = y;
  assign vga.video_on = x < 10'd640 && y < 10'd480;
endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: two generators (DIV=4 active-low, DIV=2 active-high) compared every
// cycle with a model that derives the whole raster from clk cycles since reset release.
module tb_vga_sync;
  logic clk = 1'b0;
  logic rst4 = 1'b0, rst2 = 1'b0;
  logic [9:0] fx, fy;
  int t4 = 0, t2 = 0, checks = 0, errors = 0, n, tf;
  always #5 clk = ~clk;
  vga_sync_if v4 ();
  vga_sync_if v2 ();
  vga_sync #(.DIV(4), .SYNC_ACT(1'b0)) u4 (.clk(clk), .reset(rst4), .vga(v4));
  vga_sync #(.DIV(2), .SYNC_ACT(1'b1)) u2 (.clk(clk), .reset(rst2), .vga(v2));

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference: pixel index = t/DIV, x = pixel mod 800, y = line mod 525
  task automatic cmp(string id, int t, int div, int act, int hs, int vs, int vo,
                     int pt, int ft, int px, int py);
    int p = t / div;
    int ex = p % 800;
    int ey = (p / 800) % 525;
    check({id, ".pix_x"}, px, ex);
    check({id, ".pix_y"}, py, ey);
    check({id, ".p_tick"}, pt, (t % div == div - 1) ? 1 : 0);
    check({id, ".f_tick"}, ft, (t > 0 && t % (800 * 525 * div) == 0) ? 1 : 0);
    check({id, ".hsync"}, hs, (ex >= 656 && ex <= 751) ? act : 1 - act);
    check({id, ".vsync"}, vs, (ey == 490 || ey == 491) ? act : 1 - act);
    check({id, ".video_on"}, vo, (ex < 640 && ey < 480) ? 1 : 0);
  endtask

  task automatic cyc(int k);
    repeat (k) begin
      @(posedge clk);
      if (rst4) t4++;
      if (rst2) t2++;
      @(negedge clk);
      cmp("d4", t4, 4, 0, int'(v4.hsync), int'(v4.vsync), int'(v4.video_on),
          int'(v4.p_tick), int'(v4.f_tick), int'(v4.pix_x), int'(v4.pix_y));
      cmp("d2", t2, 2, 1, int'(v2.hsync), int'(v2.vsync), int'(v2.video_on),
          int'(v2.p_tick), int'(v2.f_tick), int'(v2.pix_x), int'(v2.pix_y));
    end
  endtask

  // jump the DIV=4 raster to (px, line) of the given frame, keeping prescaler phase
  task automatic warp4(int line, int px, int frame);
    int tgt = ((frame * 525 + line) * 800 + px) * 4 + t4 % 4;
    fx = 10'(px);
    fy = 10'(line);
    force u4.x = fx;
    force u4.y = fy;
    t4 = tgt;
    #1;
    release u4.x;
    release u4.y;
  endtask

  initial begin
    cyc(3);
    rst4 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc(3);
      check("p_tick_before_edge", int'(v4.p_tick), 1);
      cyc(1);
      check("pix_x_after_tick", int'(v4.pix_x), k);
      check("hsync_idle", int'(v4.hsync), 1);
      check("vsync_idle", int'(v4.vsync), 1);
      check("video_on_start", int'(v4.video_on), 1);
    end
    n = 0;
    while (v4.pix_x != 10'd655 && n < 4000) begin cyc(1); n++; end
    check("reach_x655", int'(v4.pix_x), 655);
    n = 0;
    while (v4.pix_x != 10'd656 && n < 10) begin cyc(1); n++; end
    check("hsync_at_656", int'(v4.hsync), 0);
    n = 0;
    while (v4.hsync == 1'b0 && n < 1000) begin cyc(1); n++; end
    check("hsync_width4", n, 384);
    check("hsync_end_x", int'(v4.pix_x), 752);
    n = 0;
    while (v4.pix_y != 10'd1 && n < 1000) begin cyc(1); n++; end
    check("line_len4", t4, 3200);
    warp4(478, int'($urandom_range(1, 600)), 0);
    n = 0;
    while (v4.pix_y != 10'd480 && n < 7000) begin cyc(1); n++; end
    check("y480_x", int'(v4.pix_x), 0);
    check("y480_video_off", int'(v4.video_on), 0);
    warp4(489, int'($urandom_range(1, 600)), 0);
    n = 0;
    while (v4.vsync != 1'b0 && n < 7000) begin cyc(1); n++; end
    check("vsync_on_y", int'(v4.pix_y), 490);
    check("vsync_on_x", int'(v4.pix_x), 0);
    n = 0;
    while (v4.vsync == 1'b0 && n < 8000) begin cyc(1); n++; end
    check("vsync_width4", n, 6400);
    check("vsync_end_y", int'(v4.pix_y), 492);
    warp4(523, int'($urandom_range(1, 600)), 0);
    n = 0;
    while (v4.f_tick != 1'b1 && n < 7000) begin cyc(1); n++; end
    check("f_tick_time", t4, 1680000);
    check("f_tick_x", int'(v4.pix_x), 0);
    check("f_tick_y", int'(v4.pix_y), 0);
    tf = t4;
    cyc(1);
    check("f_tick_one_clk", int'(v4.f_tick), 0);
    warp4(524, int'($urandom_range(1, 600)), 1);
    n = 0;
    while (v4.f_tick != 1'b1 && n < 4000) begin cyc(1); n++; end
    check("f_tick_period", t4 - tf, 1680000);
    n = 0;
    while (v4.pix_x != 10'd700 && n < 3000) begin cyc(1); n++; end
    check("reach_x700", int'(v4.pix_x), 700);
    check("hsync_mid_pulse", int'(v4.hsync), 0);
    #2;
    rst4 = 1'b0;
    t4 = 0;
    #1;
    check("async_rst_x", int'(v4.pix_x), 0);
    check("async_rst_hsync", int'(v4.hsync), 1);
    check("async_rst_video_on", int'(v4.video_on), 1);
    check("async_rst_p_tick", int'(v4.p_tick), 0);
    cyc($urandom_range(1, 5));
    rst4 = 1'b1;
    cyc(3);
    check("restart_p_tick", int'(v4.p_tick), 1);
    cyc(1);
    check("restart_x", int'(v4.pix_x), 1);
    rst2 = 1'b1;
    n = 0;
    while (v2.hsync != 1'b1 && n < 2000) begin cyc(1); n++; end
    check("hsync2_on_x", int'(v2.pix_x), 656);
    n = 0;
    while (v2.hsync == 1'b1 && n < 1000) begin cyc(1); n++; end
    check("hsync_width2", n, 192);
    check("hsync2_end_x", int'(v2.pix_x), 752);
    n = 0;
    while (v2.pix_y != 10'd1 && n < 2000) begin cyc(1); n++; end
    check("line_len2", t2, 1600);
    repeat (6) begin
      cyc($urandom_range(1, 1700));
      #($urandom_range(1, 3));
      rst2 = 1'b0;
      t2 = 0;
      #1;
      check("async_rst2_x", int'(v2.pix_x), 0);
      check("async_rst2_hsync", int'(v2.hsync), 0);
      check("async_rst2_p_tick", int'(v2.p_tick), 0);
      cyc($urandom_range(1, 3));
      rst2 = 1'b1;
    end
    cyc(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 The block SHALL provide parameter DIV, default 4, giving clk cycles per pixel (pixel clock = clk/DIV, 25 MHz from 100 MHz); legal values are 2 to 16.
REQ-002 The block SHALL provide parameter SYNC_ACT, default 0, giving the asserted level of hsync and vsync (0 = active-low, per 640x480 at 60 Hz).
REQ-003 The block SHALL provide port clk, input, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-004 The block SHALL provide port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL provide port hsync, output, 1 bit: the registered horizontal sync.
REQ-006 The block SHALL provide port vsync, output, 1 bit: the registered vertical sync.
REQ-007 The block SHALL provide port video_on, output, 1 bit: high while (pix_x < 640) and (pix_y < 480).
REQ-008 The block SHALL provide port p_tick, output, 1 bit: a one-clk pulse at each pixel boundary.
REQ-009 The block SHALL provide port f_tick, output, 1 bit: a one-clk pulse at the first pixel of each frame.
REQ-010 The block SHALL provide port pix_x, output, 10 bits: the current horizontal count, 0 to 799.
REQ-011 The block SHALL provide port pix_y, output, 10 bits: the current vertical count, 0 to 524.

Function
REQ-012 The block SHALL contain a prescaler counter that counts 0 to DIV-1 and wraps to 0.
REQ-013 p_tick SHALL be high exactly in the clk cycle in which the prescaler equals DIV-1.
REQ-014 The horizontal counter (pix_x) SHALL advance only on p_tick and SHALL wrap from 799 to 0.
REQ-015 The vertical counter (pix_y) SHALL advance only on a p_tick where pix_x = 799, and SHALL wrap from 524 to 0.
REQ-016 Horizontal timing SHALL be: display 0-639, front porch 640-655, sync 656-751, back porch 752-799.
REQ-017 Vertical timing SHALL be: display 0-479, front porch 480-489, sync 490-491, back porch 492-524.
REQ-018 hsync SHALL be a flip-flop loaded from the next-state horizontal count, so it equals SYNC_ACT in exactly the cycles where pix_x is 656-751, with zero skew relative to pix_x.
REQ-019 vsync SHALL be registered in the same way from the next-state vertical count, and SHALL equal SYNC_ACT in exactly the cycles where pix_y is 490-491.
REQ-020 video_on SHALL be decoded combinationally from the registered counters and SHALL have no added latency relative to pix_x and pix_y.
REQ-021 f_tick SHALL be high for one clk cycle on the p_tick at which the counters roll from (799,524) to (0,0), i.e. coincident with the wrap.
REQ-022 All counter comparisons SHALL be unsigned on 10 bits; no count SHALL ever exceed its wrap value.
REQ-023 If a counter holds an out-of-range value (e.g. after a glitch), it SHALL wrap to 0 on the next advance.
REQ-024 One frame SHALL be exactly 800 x 525 x DIV clk cycles, i.e. 1,680,000 cycles at DIV=4.
REQ-025 One line SHALL be exactly 800 x DIV clk cycles.

Reset
REQ-026 While reset = 0, the prescaler, pix_x and pix_y SHALL be 0, and p_tick and f_tick SHALL be 0.
REQ-027 While reset = 0, hsync and vsync SHALL be at ~SYNC_ACT (deasserted), and video_on SHALL be 1 (since the counts are 0,0).
REQ-028 Reset assertion SHALL take effect immediately, without waiting for a clk edge, including in the middle of a sync pulse or line.
REQ-029 On reset release, the first p_tick SHALL occur DIV clk edges after release, and pix_x SHALL become 1 on that edge.

Verification
REQ-030 The bench SHALL cover: hold reset low for 3 clk, release -> p_tick on edges 4, 8, 12; pix_x = 1, 2, 3 after each tick; hsync and vsync deasserted; video_on = 1.
REQ-031 The bench SHALL cover: run to pix_x = 655 then one p_tick -> pix_x = 656 and hsync = SYNC_ACT in the same cycle; hsync deasserted again when pix_x = 752; pulse width = 96 x DIV = 384 clk.
REQ-032 The bench SHALL cover: pix_x = 799, pix_y = 479, then p_tick -> pix_x = 0, pix_y = 480, video_on = 0; the line at pix_y = 490 has vsync asserted for 2 lines (6400 clk at DIV=4).
REQ-033 The bench SHALL cover: pix_x = 799, pix_y = 524, then p_tick -> pix_x = 0, pix_y = 0, f_tick = 1 for one clk; consecutive f_tick pulses 1,680,000 clk apart.
REQ-034 The bench SHALL cover: assert reset during the hsync pulse (pix_x = 700) -> outputs return to reset values asynchronously, before the next clk edge; after release, counting restarts from 0 per REQ-029.
REQ-035 The bench SHALL cover: re-run with DIV=2 and SYNC_ACT=1 -> line = 1600 clk; hsync is high during 656-751, low otherwise.
